// File: rtl/fpu_op_dispatcher.sv
// -----------------------------------------------------------------------------
// fpu_op_dispatcher
//
// Purpose:
//   Sends one floating-point operation at a time to an FPU core and returns
//   its result. A request is accepted on a valid/ready port. Its operands go
//   out to the FPU, and a one-cycle start pulse launches it. The block then
//   waits for done, with a timeout. The result and the request tag leave on a
//   valid/ready response port. No operand bits are interpreted: results pass
//   through bit-exact.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles without fpu_done before the op is aborted
//                   (min 2)
//   TAG_W           width of the request/response tag
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   in_a, in_b, in_op   operands and op select (00 add, 01 sub, 10 mul, 11 div)
//   in_tag              request tag, echoed on the response
//   fpu_a, fpu_b        operands to the FPU; held from one acceptance to the
//                       next
//   fpu_sel             operation select to the FPU
//   fpu_start           one-cycle launch pulse
//   fpu_result          FPU result
//   fpu_done            FPU completion level; may still be high from the
//                       previous op
//   out_valid/out_ready response handshake
//   out_result, out_tag result and tag of the completed op
//   out_timeout         1 = op aborted by timeout; out_result is the quiet NaN
//                       7FC00000
//   busy                high in any state other than IDLE
//
// Optional feature (macro FPU_DISP_PERF_EN):
//   Adds three saturating counters, all cleared by reset:
//   perf_ops       (32)  response handshakes
//   perf_timeouts  (16)  timeout responses produced
//   perf_last_lat  (16)  cycles from fpu_start to done/timeout, most recent op
// -----------------------------------------------------------------------------
module fpu_op_dispatcher #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TAG_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  // request port
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  // FPU start/done interface
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_sel,
  output logic             fpu_start,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_done,
  // response port
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_timeout,
  output logic             busy
`ifdef FPU_DISP_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [15:0]      perf_timeouts,
  output logic [15:0]      perf_last_lat
`endif
);

  // The counter only has to reach TIMEOUT_CYCLES-1. That is the value it
  // holds in the last allowed WAIT cycle.
  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [1:0]         r_fpu_sel;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_out_result;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_timeout;

  logic               w_accept;
  logic               w_done_ok;
  logic               w_timeout;
  logic               w_handshake;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff samples the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake/control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    fpu_start   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    w_handshake = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        fpu_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // In the first WAIT cycle (counter still 0), done can only be the
        // level left over from the previous op, so it is ignored. If done
        // and the timeout fall in the same cycle, done wins.
        w_done_ok = fpu_done && (r_cnt != '0);
        w_timeout = !w_done_ok && (r_cnt == LAST_WAIT);
        if (w_done_ok || w_timeout) w_state_nxt = S_HOLD;
      end

      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand/tag capture, wait counter, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fpu_a       <= '0;
      r_fpu_b       <= '0;
      r_fpu_sel     <= '0;
      r_tag         <= '0;
      r_cnt         <= '0;
      r_out_result  <= '0;
      r_out_tag     <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      // The operand registers keep their values in IDLE. They change only
      // when a new request is accepted.
      if (w_accept) begin
        r_fpu_a   <= in_a;
        r_fpu_b   <= in_b;
        r_fpu_sel <= in_op;
        r_tag     <= in_tag;
      end

      if (r_state == S_LAUNCH)    r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);

      if (w_done_ok) begin
        r_out_result  <= fpu_result;
        r_out_tag     <= r_tag;
        r_out_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_out_result  <= QNAN;
        r_out_tag     <= r_tag;
        r_out_timeout <= 1'b1;
      end
    end
  end

  assign fpu_a       = r_fpu_a;
  assign fpu_b       = r_fpu_b;
  assign fpu_sel     = r_fpu_sel;
  assign out_result  = r_out_result;
  assign out_tag     = r_out_tag;
  assign out_timeout = r_out_timeout;

`ifdef FPU_DISP_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_ops;
  logic [15:0] r_perf_timeouts;
  logic [15:0] r_perf_last_lat;
  logic [31:0] w_lat;

  // In WAIT cycle k the counter holds k-1, and WAIT cycle k is k cycles after
  // the start pulse.
  assign w_lat = 32'(r_cnt) + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_ops      <= '0;
      r_perf_timeouts <= '0;
      r_perf_last_lat <= '0;
    end else begin
      if (w_handshake && (r_perf_ops != '1))
        r_perf_ops <= r_perf_ops + 32'd1;
      if (w_timeout && (r_perf_timeouts != '1))
        r_perf_timeouts <= r_perf_timeouts + 16'd1;
      if (w_done_ok || w_timeout)
        r_perf_last_lat <= (w_lat > 32'd65535) ? 16'hFFFF : w_lat[15:0];
    end
  end

  assign perf_ops      = r_perf_ops;
  assign perf_timeouts = r_perf_timeouts;
  assign perf_last_lat = r_perf_last_lat;
`endif

endmodule
